// File: rtl/step_coord_pkg.sv
// Shared types and default constants for the ODE-solver step coordinator.
// Contents: FSM state enum (IDLE/STEP/INTERP/DONE), state width, default parameter values.
package step_coord_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StStep,
    StInterp,
    StDone
  } state_e;

  localparam int unsigned DefNumCh         = 4;
  localparam int unsigned DefStepW         = 16;
  localparam int unsigned DefRamAddrW      = 13;
  localparam int unsigned DefChStride      = 200;
  localparam int unsigned DefTimeoutCycles = 1024;

endpackage

// File: rtl/step_channel_select.sv
// Combinational channel finder: lowest set bit of i_mask at or above i_cur (i_above=0),
// or strictly above i_cur (i_above=1).
// Ports:
//   i_mask   in  NUM_CH  participating channels
//   i_cur    in  CH_W    search reference index
//   i_above  in  1       1 = skip i_cur itself
//   o_next   out CH_W    selected channel (0 when none)
//   o_none   out 1       no candidate channel found
module step_channel_select #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  input  logic              i_above,
  output logic [CH_W-1:0]   o_next,
  output logic              o_none
);

  always_comb begin
    o_next = '0;
    o_none = 1'b1;
    // Scan downwards so the lowest qualifying channel is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && ((i > int'(i_cur)) || (!i_above && (i == int'(i_cur))))) begin
        o_next = CH_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/step_coordinator.sv
// Top-level sequencer of the ODE solver datapath over NUM_CH solver channels.
// A Process request runs Num_Steps steps; each step enables every unmasked channel in
// ascending order, then starts the interpolator. Done_Processing pulses at the end; INT aborts.
// Optional watchdog: define STEP_COORD_TIMEOUT_EN to bound every STEP/INTERP wait by
// TIMEOUT_CYCLES (sets sticky Error and finishes the run).
// Ports:
//   CLK, RST (sync, active high), INT (abort), Process/Num_Steps/Channel_Mask (start request),
//   Done_Processing (done pulse), Solver_Enable/Solver_End (channel handshake),
//   Step_RAM_Base (active region base), Change_State/Change_State_End (interpolator handshake),
//   Step_Index (completed steps), Busy, Error (watchdog flag).
module step_coordinator
  import step_coord_pkg::*;
#(
  parameter int unsigned NUM_CH            = DefNumCh,
  parameter int unsigned STEP_W            = DefStepW,
  parameter int unsigned RAM_ADDRESS_WIDTH = DefRamAddrW,
  parameter int unsigned CH_STRIDE         = DefChStride,
  parameter int unsigned TIMEOUT_CYCLES    = DefTimeoutCycles
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         INT,
  input  logic                         Process,
  input  logic [STEP_W-1:0]            Num_Steps,
  input  logic [NUM_CH-1:0]            Channel_Mask,
  output logic                         Done_Processing,
  output logic [NUM_CH-1:0]            Solver_Enable,
  input  logic [NUM_CH-1:0]            Solver_End,
  output logic [RAM_ADDRESS_WIDTH-1:0] Step_RAM_Base,
  output logic                         Change_State,
  input  logic                         Change_State_End,
  output logic [STEP_W-1:0]            Step_Index,
  output logic                         Busy,
  output logic                         Error
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("step_coordinator: NUM_CH and TIMEOUT_CYCLES must be >= 1");
  end

  state_e              r_state, w_next;
  logic [ChW-1:0]      r_ch;
  logic [NUM_CH-1:0]   r_mask;
  logic [STEP_W-1:0]   r_num, r_idx;
  logic                r_cs_entry, r_error;

  logic [NUM_CH-1:0]   w_sel_mask;
  logic [ChW-1:0]      w_sel_cur, w_sel_ch;
  logic                w_sel_above, w_sel_none;
  logic                w_start, w_advance, w_step_done, w_tmo_fire, w_timeout, w_last_step;

  // One finder serves both the initial pick (from the live mask) and the in-run advance.
  always_comb begin
    w_sel_mask  = (r_state == StIdle) ? Channel_Mask : r_mask;
    w_sel_cur   = (r_state == StStep) ? r_ch : '0;
    w_sel_above = (r_state == StStep);
  end

  step_channel_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (ChW)
  ) u_sel (
    .i_mask  (w_sel_mask),
    .i_cur   (w_sel_cur),
    .i_above (w_sel_above),
    .o_next  (w_sel_ch),
    .o_none  (w_sel_none)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    w_step_done = 1'b0;
    w_tmo_fire  = 1'b0;
    w_last_step = ((r_idx + STEP_W'(1)) == r_num);
    if (INT && (r_state != StIdle)) begin
      w_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          // An abort request also blocks a simultaneous start.
          if (Process && !INT) begin
            w_start = 1'b1;
            w_next  = ((Num_Steps == '0) || (Channel_Mask == '0)) ? StDone : StStep;
          end
        end
        StStep: begin
          if (Solver_End[r_ch]) begin
            if (w_sel_none) w_next = StInterp;
            else            w_advance = 1'b1;
          end else if (w_timeout) begin
            w_next     = StDone;
            w_tmo_fire = 1'b1;
          end
        end
        StInterp: begin
          if (Change_State_End) begin
            w_step_done = 1'b1;
            if (w_last_step) begin
              w_next = StDone;
            end else begin
              w_next    = StStep;
              w_advance = 1'b1;
            end
          end else if (w_timeout) begin
            w_next     = StDone;
            w_tmo_fire = 1'b1;
          end
        end
        StDone:  w_next = StIdle;
        default: w_next = StIdle;
      endcase
    end
  end

  // Run bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ch       <= '0;
      r_mask     <= '0;
      r_num      <= '0;
      r_idx      <= '0;
      r_cs_entry <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_start) begin
        r_num  <= Num_Steps;
        r_mask <= Channel_Mask;
        r_idx  <= '0;
        r_ch   <= w_sel_ch;
      end else if (w_advance) begin
        r_ch <= w_sel_ch;
      end
      if (w_step_done) r_idx <= r_idx + STEP_W'(1);
      r_cs_entry <= (w_next == StInterp) && (r_state != StInterp);
      // Without the watchdog w_tmo_fire is constant 0, so Error never sets.
      if (w_start)         r_error <= 1'b0;
      else if (w_tmo_fire) r_error <= 1'b1;
    end
  end

`ifdef STEP_COORD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_cnt;

  // Restarts on every state entry and on each channel hand-over.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || w_advance ||
                 !((r_state == StStep) || (r_state == StInterp))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // Outputs
  always_comb begin
    Solver_Enable = '0;
    Step_RAM_Base = '0;
    if (r_state == StStep) begin
      Solver_Enable[r_ch] = 1'b1;
      Step_RAM_Base       = RAM_ADDRESS_WIDTH'(32'(r_ch) * CH_STRIDE);
    end
    Change_State    = (r_state == StInterp) && r_cs_entry;
    Done_Processing = (r_state == StDone);
    Busy            = (r_state != StIdle);
    Step_Index      = r_idx;
    Error           = r_error;
  end

endmodule

// File: tb/tb_step_coordinator.sv
// Self-checking bench for step_coordinator: randomized channel/interpolator responders,
// expected enable/base sequence built from the mask and step count.
module tb_step_coordinator;

  localparam int unsigned NumCh     = 4;
  localparam int unsigned StepW     = 16;
  localparam int unsigned AddrW     = 13;
  localparam int unsigned Stride    = 200;
  localparam int unsigned Tmo       = 16;
  localparam int          MaxCycles = 400;

  logic              CLK = 1'b0;
  logic              RST, INT, Process, Change_State_End;
  logic [StepW-1:0]  Num_Steps;
  logic [NumCh-1:0]  Channel_Mask, Solver_End, Solver_Enable;
  logic              Done_Processing, Change_State, Busy, Error;
  logic [AddrW-1:0]  Step_RAM_Base;
  logic [StepW-1:0]  Step_Index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  step_coordinator #(
    .NUM_CH            (NumCh),
    .STEP_W            (StepW),
    .RAM_ADDRESS_WIDTH (AddrW),
    .CH_STRIDE         (Stride),
    .TIMEOUT_CYCLES    (Tmo)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .INT              (INT),
    .Process          (Process),
    .Num_Steps        (Num_Steps),
    .Channel_Mask     (Channel_Mask),
    .Done_Processing  (Done_Processing),
    .Solver_Enable    (Solver_Enable),
    .Solver_End       (Solver_End),
    .Step_RAM_Base    (Step_RAM_Base),
    .Change_State     (Change_State),
    .Change_State_End (Change_State_End),
    .Step_Index       (Step_Index),
    .Busy             (Busy),
    .Error            (Error)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One run from a Process pulse. abort_ch >= 0 raises INT together with that channel's End.
  task automatic run_job(input logic [3:0] mask, input int n, input int abort_ch);
    logic [3:0] exp_en[$];
    int         exp_base[$];
    logic [3:0] en, prev, sp;
    int k, cs_cnt, dn_cnt, first_en, done_at, age, delay, cse_wait, exp_steps;
    bit pend, aborted;
    k = 0; cs_cnt = 0; dn_cnt = 0; first_en = -1; done_at = -1; age = 0; delay = 0;
    cse_wait = 0; pend = 0; aborted = 0; prev = '0;
    for (int s = 0; s < n; s++)
      for (int ch = 0; ch < NumCh; ch++)
        if (mask[ch]) begin
          exp_en.push_back(4'(1 << ch));
          exp_base.push_back((ch * Stride) % (1 << AddrW));
        end
    exp_steps = (mask != 0) ? n : 0;

    Process = 1'b1; Num_Steps = StepW'(n); Channel_Mask = mask;
    @(negedge CLK);
    Process = 1'b0;
    for (int c = 1; c <= MaxCycles && dn_cnt == 0 && !aborted; c++) begin
      en = Solver_Enable;
      Solver_End = '0;
      Change_State_End = 1'b0;
      if (en != 0 && en != prev) begin
        if (first_en < 0) first_en = c;
        if (k < exp_en.size()) begin
          check_eq("enable", 32'(en), 32'(exp_en[k]));
          check_eq("ram_base", 32'(Step_RAM_Base), exp_base[k]);
        end else begin
          check_eq("extra_enable", 32'(en), 0);
        end
        k++; age = 0; delay = $urandom_range(0, 4);
      end else begin
        age++;
      end
      if (Change_State) begin
        cs_cnt++; pend = 1; cse_wait = $urandom_range(0, 3);
      end
      if (Done_Processing) begin
        dn_cnt++; done_at = c;
      end
      if (abort_ch >= 0 && en == 4'(1 << abort_ch)) begin
        INT = 1'b1; Solver_End = en;
        @(negedge CLK);
        INT = 1'b0; Solver_End = '0;
        check_eq("abort_busy", 32'(Busy), 0);
        check_eq("abort_enable", 32'(Solver_Enable), 0);
        aborted = 1;
      end else begin
        if (en != 0 && age >= delay) Solver_End = en;
        sp = 4'($urandom);
        if ($urandom_range(0, 3) == 0) Solver_End = Solver_End | (sp & ~en);
        if (pend) begin
          if (cse_wait == 0) begin
            Change_State_End = 1'b1; pend = 0;
          end else begin
            cse_wait--;
          end
        end else if (en != 0 && $urandom_range(0, 7) == 0) begin
          Change_State_End = 1'b1;
        end
        prev = en;
        @(negedge CLK);
      end
    end
    Solver_End = '0;
    Change_State_End = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (Change_State) cs_cnt++;
      if (Done_Processing) dn_cnt++;
      @(negedge CLK);
    end
    if (aborted) begin
      check_eq("abort_change_state", cs_cnt, 0);
      check_eq("abort_done", dn_cnt, 0);
      check_eq("abort_idle", 32'(Busy), 0);
      return;
    end
    if (dn_cnt == 0) begin
      INT = 1'b1; @(negedge CLK); INT = 1'b0;
    end
    check_eq("done_count", dn_cnt, 1);
    check_eq("enable_count", k, exp_en.size());
    check_eq("change_state_count", cs_cnt, exp_steps);
    check_eq("step_index", 32'(Step_Index), exp_steps);
    check_eq("busy_after", 32'(Busy), 0);
    check_eq("error_after", 32'(Error), 0);
    if (exp_en.size() > 0) check_eq("enable_latency", first_en, 1);
    else                   check_eq("done_latency", done_at, 1);
  endtask

  initial begin
    int done_at;
    logic err_at_done;
    RST = 1'b1; INT = 1'b0; Process = 1'b0; Num_Steps = '0; Channel_Mask = '0;
    Solver_End = '0; Change_State_End = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_busy", 32'(Busy), 0);
    check_eq("rst_done", 32'(Done_Processing), 0);
    check_eq("rst_enable", 32'(Solver_Enable), 0);
    check_eq("rst_base", 32'(Step_RAM_Base), 0);
    check_eq("rst_change_state", 32'(Change_State), 0);
    check_eq("rst_step_index", 32'(Step_Index), 0);
    check_eq("rst_error", 32'(Error), 0);
    RST = 1'b0;
    @(negedge CLK);

    run_job(4'b1111, 2, -1);
    run_job(4'b1010, 1, -1);
    run_job(4'b1111, 0, -1);
    run_job(4'b0000, 3, -1);
    run_job(4'b1111, 1, 2);
    for (int j = 0; j < 20; j++)
      run_job(4'($urandom_range(0, 15)), $urandom_range(0, 4), -1);

    // Channel never finishes.
    Process = 1'b1; Num_Steps = 1; Channel_Mask = 4'b0001;
    @(negedge CLK);
    Process = 1'b0;
    done_at = -1; err_at_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Done_Processing && done_at < 0) begin
        done_at = c; err_at_done = Error;
      end
      @(negedge CLK);
    end
`ifdef STEP_COORD_TIMEOUT_EN
    check_eq("timeout_done_at", done_at, Tmo + 2);
    check_eq("timeout_error", 32'(err_at_done), 1);
    check_eq("timeout_error_sticky", 32'(Error), 1);
    check_eq("timeout_idle", 32'(Busy), 0);
`else
    check_eq("no_timeout_done", done_at, -1);
    check_eq("no_timeout_error", 32'(Error), 0);
    check_eq("no_timeout_busy", 32'(Busy), 1);
    INT = 1'b1; @(negedge CLK); INT = 1'b0;
    check_eq("no_timeout_abort", 32'(Busy), 0);
`endif
    run_job(4'b0011, 1, -1);

    // Reset in the middle of a run.
    Process = 1'b1; Num_Steps = 3; Channel_Mask = 4'b1111;
    @(negedge CLK);
    Process = 1'b0;
    repeat (4) @(negedge CLK);
    check_eq("midrun_busy", 32'(Busy), 1);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("midrun_rst_busy", 32'(Busy), 0);
    check_eq("midrun_rst_enable", 32'(Solver_Enable), 0);
    check_eq("midrun_rst_index", 32'(Step_Index), 0);
    RST = 1'b0;
    @(negedge CLK);
    run_job(4'b0100, 2, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
